// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: widths, op encodings, FSM states and latch sizing.
package mem_stage_pkg;

    localparam int unsigned DBITS     = 32;
    localparam int unsigned IOPBITS   = 6;
    localparam int unsigned REGBITS   = 5;
    localparam int unsigned ADDR_BITS = 32;

    localparam logic [IOPBITS-1:0] LB_I  = 6'h10;
    localparam logic [IOPBITS-1:0] LH_I  = 6'h11;
    localparam logic [IOPBITS-1:0] LW_I  = 6'h12;
    localparam logic [IOPBITS-1:0] LBU_I = 6'h13;
    localparam logic [IOPBITS-1:0] LHU_I = 6'h14;
    localparam logic [IOPBITS-1:0] SB_I  = 6'h18;
    localparam logic [IOPBITS-1:0] SH_I  = 6'h19;
    localparam logic [IOPBITS-1:0] SW_I  = 6'h1A;

    // MEM latch layout, MSB first: valid, wr_reg, rd, result, inst_count
    localparam int unsigned WB_VALID_W = 1;
    localparam int unsigned WB_WR_W    = 1;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_e;

    function automatic int unsigned mem_latch_w(input int unsigned dbits, input int unsigned regbits);
        return WB_VALID_W + WB_WR_W + regbits + 2 * dbits;
    endfunction

    function automatic logic op_is_load(input logic [IOPBITS-1:0] op);
        return (op == LB_I) || (op == LH_I) || (op == LW_I) || (op == LBU_I) || (op == LHU_I);
    endfunction

    function automatic logic op_is_store(input logic [IOPBITS-1:0] op);
        return (op == SB_I) || (op == SH_I) || (op == SW_I);
    endfunction

endpackage

// File: rtl/mem_stage_lane_align.sv
// Combinational store-lane / byte-enable generator and load extract/extend unit.
module mem_lane_align
    import mem_stage_pkg::*;
(
    input  logic [IOPBITS-1:0] op_i,
    input  logic [1:0]         addr_lo_i,
    input  logic [DBITS-1:0]   store_data_i,
    input  logic [DBITS-1:0]   rdata_i,
    output logic [3:0]         be_o,
    output logic [DBITS-1:0]   wdata_o,
    output logic [DBITS-1:0]   load_data_o,
    output logic               misalign_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        be_o        = '0;
        wdata_o     = '0;
        load_data_o = '0;
        misalign_o  = 1'b0;
        case (op_i)
            SB_I: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{store_data_i[7:0]}};
            end
            SH_I: begin
                be_o       = 4'b0011 << addr_lo_i;
                wdata_o    = {2{store_data_i[15:0]}};
                misalign_o = addr_lo_i[0];
            end
            SW_I: begin
                be_o       = 4'hF;
                wdata_o    = store_data_i;
                misalign_o = (addr_lo_i != 2'd0);
            end
            LB_I:  load_data_o = {{24{byte_sel[7]}}, byte_sel};
            LBU_I: load_data_o = {24'd0, byte_sel};
            LH_I: begin
                load_data_o = {{16{half_sel[15]}}, half_sel};
                misalign_o  = addr_lo_i[0];
            end
            LHU_I: begin
                load_data_o = {16'd0, half_sel};
                misalign_o  = addr_lo_i[0];
            end
            LW_I: begin
                load_data_o = rdata_i;
                misalign_o  = (addr_lo_i != 2'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: RV32 loads/stores over a req/ack data-memory port, stalls upstream while busy.
// Optional decode-bypass outputs are enabled by defining MEM_FWD_EN.
module mem_stage #(
    parameter int unsigned DBITS     = mem_stage_pkg::DBITS,
    parameter int unsigned IOPBITS   = mem_stage_pkg::IOPBITS,
    parameter int unsigned REGBITS   = mem_stage_pkg::REGBITS,
    parameter int unsigned ADDR_BITS = mem_stage_pkg::ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ex_valid,
    input  logic [IOPBITS-1:0]   ex_op,
    input  logic [DBITS-1:0]     ex_alu_out,
    input  logic [DBITS-1:0]     ex_store_data,
    input  logic [REGBITS-1:0]   ex_rd,
    input  logic                 ex_wr_reg,
    input  logic [DBITS-1:0]     ex_inst_count,
    output logic                 mem_stall,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [ADDR_BITS-1:0] dmem_addr,
    output logic [DBITS-1:0]     dmem_wdata,
    output logic [3:0]           dmem_be,
    input  logic [DBITS-1:0]     dmem_rdata,
    input  logic                 dmem_ack,
    output logic                 wb_valid,
    output logic [DBITS-1:0]     wb_result,
    output logic [REGBITS-1:0]   wb_rd,
    output logic                 wb_wr_reg,
    output logic [DBITS-1:0]     wb_inst_count,
`ifdef MEM_FWD_EN
    output logic                 fwd_valid,
    output logic [REGBITS-1:0]   fwd_rd,
    output logic [DBITS-1:0]     fwd_data,
    output logic                 fwd_busy,
`endif
    output logic                 misalign_err
);
    import mem_stage_pkg::*;

    localparam int unsigned LATCH_W = mem_latch_w(DBITS, REGBITS);

    state_e               state_q, state_d;
    logic [IOPBITS-1:0]   op_q, op_d;
    logic [DBITS-1:0]     addr_q, addr_d, sd_q, sd_d, tag_q, tag_d;
    logic [REGBITS-1:0]   rd_q, rd_d;
    logic                 wr_q, wr_d;
    logic                 misalign_q, misalign_d;
    logic [LATCH_W-1:0]   wb_q, wb_d;

    logic [IOPBITS-1:0]   cur_op;
    logic [DBITS-1:0]     cur_addr, cur_sd, cur_tag;
    logic [REGBITS-1:0]   cur_rd;
    logic                 cur_wr, cur_load, cur_store;
    logic                 req, stall, complete;
    logic [3:0]           lane_be;
    logic [DBITS-1:0]     lane_wdata, lane_load;
    logic                 lane_misalign;

    // In ACCESS the request is driven from the held copy so it stays stable until ack
    always_comb begin
        if (state_q == S_ACCESS) begin
            cur_op = op_q; cur_addr = addr_q; cur_sd = sd_q;
            cur_tag = tag_q; cur_rd = rd_q; cur_wr = wr_q;
        end else begin
            cur_op = ex_op; cur_addr = ex_alu_out; cur_sd = ex_store_data;
            cur_tag = ex_inst_count; cur_rd = ex_rd; cur_wr = ex_wr_reg;
        end
        cur_load  = op_is_load(cur_op);
        cur_store = op_is_store(cur_op);
    end

    mem_lane_align u_align (
        .op_i         (cur_op),
        .addr_lo_i    (cur_addr[1:0]),
        .store_data_i (cur_sd),
        .rdata_i      (dmem_rdata),
        .be_o         (lane_be),
        .wdata_o      (lane_wdata),
        .load_data_o  (lane_load),
        .misalign_o   (lane_misalign)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        sd_d       = sd_q;
        tag_d      = tag_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        misalign_d = misalign_q;
        wb_d       = {1'b0, wb_q[LATCH_W-2:0]};
        req        = 1'b0;
        stall      = 1'b0;
        complete   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ex_valid) begin
                    if (!(cur_load || cur_store)) begin
                        complete = 1'b1;
                    end else if (lane_misalign) begin
                        misalign_d = 1'b1;
                    end else begin
                        req = 1'b1;
                        if (dmem_ack) begin
                            complete = 1'b1;
                        end else begin
                            stall   = 1'b1;
                            state_d = S_ACCESS;
                            op_d    = ex_op;
                            addr_d  = ex_alu_out;
                            sd_d    = ex_store_data;
                            tag_d   = ex_inst_count;
                            rd_d    = ex_rd;
                            wr_d    = ex_wr_reg;
                        end
                    end
                end
            end
            S_ACCESS: begin
                req = 1'b1;
                if (dmem_ack) begin
                    complete = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (complete) begin
            wb_d = {1'b1, cur_wr & ~cur_store, cur_rd, cur_load ? lane_load : cur_addr, cur_tag};
        end
        // Outputs read as idle while reset is held low
        if (!reset) begin
            req   = 1'b0;
            stall = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            addr_q     <= '0;
            sd_q       <= '0;
            tag_q      <= '0;
            rd_q       <= '0;
            wr_q       <= 1'b0;
            misalign_q <= 1'b0;
            wb_q       <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            sd_q       <= sd_d;
            tag_q      <= tag_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            misalign_q <= misalign_d;
            wb_q       <= wb_d;
        end
    end

    assign mem_stall    = stall;
    assign dmem_req     = req;
    assign dmem_we      = req & cur_store;
    assign dmem_addr    = req ? {cur_addr[ADDR_BITS-1:2], 2'b00} : '0;
    assign dmem_wdata   = (req && cur_store) ? lane_wdata : '0;
    assign dmem_be      = (req && cur_store) ? lane_be : '0;
    assign misalign_err = misalign_q;
    assign {wb_valid, wb_wr_reg, wb_rd, wb_result, wb_inst_count} = wb_q;

`ifdef MEM_FWD_EN
    assign fwd_valid = wb_valid;
    assign fwd_rd    = wb_rd;
    assign fwd_data  = wb_result;
    assign fwd_busy  = (state_q == S_ACCESS) && op_is_load(op_q) && wr_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: zero-wait vector table plus hand-written multi-cycle sequences.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam logic [5:0] OP_ADD = 6'h01;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [5:0]  ex_op;
    logic [31:0] ex_alu_out, ex_store_data, ex_inst_count;
    logic [4:0]  ex_rd;
    logic        ex_wr_reg;
    logic        mem_stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic        wb_valid, wb_wr_reg, misalign_err;
    logic [31:0] wb_result, wb_inst_count;
    logic [4:0]  wb_rd;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_stage #(.DBITS(32), .IOPBITS(6), .REGBITS(5), .ADDR_BITS(32)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_op(ex_op), .ex_alu_out(ex_alu_out),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_wr_reg(ex_wr_reg),
        .ex_inst_count(ex_inst_count),
        .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .wb_valid(wb_valid), .wb_result(wb_result), .wb_rd(wb_rd),
        .wb_wr_reg(wb_wr_reg), .wb_inst_count(wb_inst_count),
        .misalign_err(misalign_err)
    );

    typedef struct {
        logic [5:0]  op;
        logic [31:0] alu;
        logic [31:0] sd;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        wr;
        logic [31:0] tag;
        logic        ack;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_res;
        logic        e_wr;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] alu, input logic [31:0] sd,
                         input logic [4:0] rd, input logic wr, input logic [31:0] tag);
        ex_valid = 1'b1; ex_op = op; ex_alu_out = alu; ex_store_data = sd;
        ex_rd = rd; ex_wr_reg = wr; ex_inst_count = tag;
    endtask

    // Load at 0x1003 acked after three stalled cycles
    task automatic load_wait(input logic [5:0] op, input logic [31:0] exp, input logic [31:0] tag);
        drive(op, 32'h0000_1003, 32'h0, 5'd7, 1'b1, tag);
        dmem_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #2;
            chk("ldw_stall", 32'(mem_stall), 32'd1);
            chk("ldw_req", 32'(dmem_req), 32'd1);
            chk("ldw_addr", dmem_addr, 32'h0000_1000);
            tick();
            chk("ldw_bubble", 32'(wb_valid), 32'd0);
        end
        dmem_ack = 1'b1;
        dmem_rdata = 32'h80FF_FFFF;
        #2;
        chk("ldw_ack_stall", 32'(mem_stall), 32'd0);
        tick();
        ex_valid = 1'b0;
        dmem_ack = 1'b0;
        chk("ldw_valid", 32'(wb_valid), 32'd1);
        chk("ldw_result", wb_result, exp);
        chk("ldw_rd", 32'(wb_rd), 32'd7);
        chk("ldw_tag", wb_inst_count, tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //           op      alu           sd            rdata         rd  wr tag ack req we addr          be       wdata         res           wr
        tbl[0] = '{OP_ADD, 32'h0000_1234, 32'h0,        32'h0,        5'd5, 1, 1, 0, 0, 0, 32'h0,        4'h0,    32'h0,        32'h0000_1234, 1};
        tbl[1] = '{SH_I,   32'h0000_2002, 32'h0000_BEEF, 32'h0,       5'd6, 1, 2, 1, 1, 1, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, 32'h0,         0};
        tbl[2] = '{SB_I,   32'h0000_0041, 32'h1234_5678, 32'h0,       5'd1, 0, 3, 1, 1, 1, 32'h0000_0040, 4'b0010, 32'h7878_7878, 32'h0,         0};
        tbl[3] = '{SW_I,   32'h0000_0080, 32'hDEAD_BEEF, 32'h0,       5'd2, 0, 4, 1, 1, 1, 32'h0000_0080, 4'hF,    32'hDEAD_BEEF, 32'h0,         0};
        tbl[4] = '{LH_I,   32'h0000_0102, 32'h0,        32'h8001_7FFF, 5'd8, 1, 5, 1, 1, 0, 32'h0000_0100, 4'h0,    32'h0,        32'hFFFF_8001, 1};
        tbl[5] = '{LHU_I,  32'h0000_0100, 32'h0,        32'h8001_F00D, 5'd9, 1, 6, 1, 1, 0, 32'h0000_0100, 4'h0,    32'h0,        32'h0000_F00D, 1};
        tbl[6] = '{LW_I,   32'h0000_0200, 32'h0,        32'hCAFE_F00D, 5'd10, 1, 7, 1, 1, 0, 32'h0000_0200, 4'h0,   32'h0,        32'hCAFE_F00D, 1};
        tbl[7] = '{LB_I,   32'h0000_0301, 32'h0,        32'h1234_8056, 5'd11, 1, 8, 1, 1, 0, 32'h0000_0300, 4'h0,   32'h0,        32'hFFFF_FF80, 1};
        tbl[8] = '{LBU_I,  32'h0000_0302, 32'h0,        32'h1234_8056, 5'd12, 1, 9, 1, 1, 0, 32'h0000_0300, 4'h0,   32'h0,        32'h0000_0034, 1};

        reset = 1'b0; ex_valid = 1'b0; ex_op = '0; ex_alu_out = '0; ex_store_data = '0;
        ex_rd = '0; ex_wr_reg = 1'b0; ex_inst_count = '0; dmem_rdata = '0; dmem_ack = 1'b0;
        tick(); tick();
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_misalign", 32'(misalign_err), 32'd0);
        chk("rst_result", wb_result, 32'd0);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].op, tbl[i].alu, tbl[i].sd, tbl[i].rd, tbl[i].wr, tbl[i].tag);
            dmem_ack = tbl[i].ack;
            dmem_rdata = tbl[i].rdata;
            #2;
            chk($sformatf("v%0d_stall", i), 32'(mem_stall), 32'd0);
            chk($sformatf("v%0d_req", i), 32'(dmem_req), 32'(tbl[i].e_req));
            chk($sformatf("v%0d_we", i), 32'(dmem_we), 32'(tbl[i].e_we));
            if (tbl[i].e_req) chk($sformatf("v%0d_addr", i), dmem_addr, tbl[i].e_addr);
            if (tbl[i].e_we) begin
                chk($sformatf("v%0d_be", i), 32'(dmem_be), 32'(tbl[i].e_be));
                chk($sformatf("v%0d_wdata", i), dmem_wdata, tbl[i].e_wdata);
            end
            tick();
            chk($sformatf("v%0d_wb_valid", i), 32'(wb_valid), 32'd1);
            chk($sformatf("v%0d_wb_wr", i), 32'(wb_wr_reg), 32'(tbl[i].e_wr));
            chk($sformatf("v%0d_wb_tag", i), wb_inst_count, tbl[i].tag);
            if (!tbl[i].e_we) begin
                chk($sformatf("v%0d_wb_result", i), wb_result, tbl[i].e_res);
                chk($sformatf("v%0d_wb_rd", i), 32'(wb_rd), 32'(tbl[i].rd));
            end
        end
        ex_valid = 1'b0;
        dmem_ack = 1'b0;
        tick();
        chk("bubble_after_table", 32'(wb_valid), 32'd0);

        load_wait(LB_I, 32'hFFFF_FF80, 32'd20);
        load_wait(LBU_I, 32'h0000_0080, 32'd21);

        // LW held in the AGEX latch while stalled, ADD follows once it drains
        drive(LW_I, 32'h0000_0500, 32'h0, 5'd3, 1'b1, 32'd30);
        dmem_rdata = 32'h1122_3344;
        #2;
        chk("b2b_stall0", 32'(mem_stall), 32'd1);
        tick();
        chk("b2b_bubble", 32'(wb_valid), 32'd0);
        dmem_ack = 1'b1;
        #2;
        chk("b2b_ack_stall", 32'(mem_stall), 32'd0);
        tick();
        dmem_ack = 1'b0;
        drive(OP_ADD, 32'h0000_0077, 32'h0, 5'd4, 1'b1, 32'd31);
        chk("b2b_lw_valid", 32'(wb_valid), 32'd1);
        chk("b2b_lw_tag", wb_inst_count, 32'd30);
        chk("b2b_lw_result", wb_result, 32'h1122_3344);
        #2;
        chk("b2b_add_stall", 32'(mem_stall), 32'd0);
        tick();
        ex_valid = 1'b0;
        chk("b2b_add_valid", 32'(wb_valid), 32'd1);
        chk("b2b_add_tag", wb_inst_count, 32'd31);
        chk("b2b_add_result", wb_result, 32'h0000_0077);

        drive(LW_I, 32'h0000_3001, 32'h0, 5'd2, 1'b1, 32'd35);
        #2;
        chk("mis_req", 32'(dmem_req), 32'd0);
        chk("mis_stall", 32'(mem_stall), 32'd0);
        tick();
        ex_valid = 1'b0;
        chk("mis_wb_valid", 32'(wb_valid), 32'd0);
        chk("mis_err", 32'(misalign_err), 32'd1);
        tick();
        chk("mis_err_held", 32'(misalign_err), 32'd1);

        drive(LW_I, 32'h0000_0400, 32'h0, 5'd9, 1'b1, 32'd40);
        #2;
        chk("rma_req", 32'(dmem_req), 32'd1);
        tick();
        reset = 1'b0;
        ex_valid = 1'b0;
        #2;
        chk("rma_req_in_rst", 32'(dmem_req), 32'd0);
        chk("rma_stall_in_rst", 32'(mem_stall), 32'd0);
        tick();
        chk("rma_wb_valid", 32'(wb_valid), 32'd0);
        chk("rma_misalign", 32'(misalign_err), 32'd0);
        chk("rma_result", wb_result, 32'd0);
        chk("rma_tag", wb_inst_count, 32'd0);
        chk("rma_rd", 32'(wb_rd), 32'd0);
        reset = 1'b1;
        tick();
        dmem_ack = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        #2;
        chk("late_ack_req", 32'(dmem_req), 32'd0);
        chk("late_ack_stall", 32'(mem_stall), 32'd0);
        tick();
        dmem_ack = 1'b0;
        chk("late_ack_wb_valid", 32'(wb_valid), 32'd0);
        chk("late_ack_result", wb_result, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the address-generate/execute stage. Consumes its latch: op, ALU result/address, store data, destination register.
- Performs RV32 loads and stores against a variable-latency data-memory port using a req/ack handshake.
- Stalls upstream while an access is outstanding.
- Registers results into the MEM latch consumed by writeback.

Parameters:
- DBITS, 32, datapath width.
- IOPBITS, 6, width of the decoded op code.
- REGBITS, 5, register index width.
- ADDR_BITS, 32, data-memory byte address width.

Ports:
- clk  in  1  clock.
- reset  in  1  reset; synchronous, active-low (0 = reset, sampled on posedge clk).
- ex_valid  in  1  AGEX latch holds a live instruction.
- ex_op  in  IOPBITS  decoded op (LB/LH/LW/LBU/LHU/SB/SH/SW/other).
- ex_alu_out  in  DBITS  ALU result, or effective address for memory ops.
- ex_store_data  in  DBITS  rs2 value for stores.
- ex_rd  in  REGBITS  destination register.
- ex_wr_reg  in  1  instruction writes rd.
- ex_inst_count  in  DBITS  instruction sequence tag.
- mem_stall  out  1  holds AGEX and all upstream stages.
- dmem_req  out  1  memory request valid.
- dmem_we  out  1  1 = write.
- dmem_addr  out  ADDR_BITS  word-aligned address ({addr[31:2],2'b00}).
- dmem_wdata  out  DBITS  lane-shifted store data.
- dmem_be  out  4  byte enables.
- dmem_rdata  in  DBITS  read data, valid when dmem_ack = 1.
- dmem_ack  in  1  one-cycle completion pulse.
- wb_valid  out  1  MEM latch valid.
- wb_result  out  DBITS  load data or passed-through ALU result.
- wb_rd  out  REGBITS  destination register.
- wb_wr_reg  out  1  write-enable to the register file.
- wb_inst_count  out  DBITS  tag passthrough.
- misalign_err  out  1  sticky: a misaligned access was seen.

Behaviour:
- FSM states: IDLE, ACCESS.
- Reset (reset = 0 at posedge):
  - State = IDLE.
  - All outputs 0, including wb_* and misalign_err.
  - Any outstanding request is abandoned. A late dmem_ack after reset is ignored.
- IDLE, non-memory op with ex_valid = 1:
  - Next edge latches wb_result = ex_alu_out, plus wb_rd, wb_wr_reg, wb_inst_count; wb_valid = 1.
  - Latency is 1 cycle. mem_stall = 0.
- IDLE, memory op with ex_valid = 1:
  - dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_be are driven combinationally in the same cycle.
  - mem_stall = 1 unless dmem_ack = 1 in that same cycle (zero-wait memory).
  - No ack: the request fields are registered and the FSM moves to ACCESS.
  - wb_valid = 0 on every edge where no instruction completes (bubble).
- ACCESS:
  - dmem_req stays 1 and all request fields are held constant. mem_stall = 1.
  - On dmem_ack: load result is latched into wb_*, wb_valid = 1, FSM returns to IDLE.
  - mem_stall drops in the ack cycle, so upstream advances on the same edge.
- Store completion: wb_valid = 1 with wb_wr_reg = 0, so the tag still retires.
- Byte enables and store lanes, with a = addr[1:0]:
  - SB: be = 4'b0001 << a; wdata = {4{sd[7:0]}}.
  - SH: be = 4'b0011 << a; wdata = {2{sd[15:0]}}.
  - SW: be = 4'hF; wdata = sd.
- Load extraction: the byte or half is selected by a, then extended:
  - LB and LH sign-extend.
  - LBU and LHU zero-extend.
- Misalignment (LH/LHU/SH with a[0] = 1; LW/SW with a ≠ 0):
  - No memory request is issued.
  - The instruction completes in 1 cycle as a bubble (wb_valid = 0).
  - misalign_err is set and held until reset.
- ex_valid = 0: treated as a bubble; no request is issued.

Optional Feature:
- Macro MEM_FWD_EN.
- When defined, extra outputs are added:
  - fwd_valid (1), fwd_rd (REGBITS), fwd_data (DBITS): combinational view of the MEM latch, for decode-stage bypass.
  - fwd_busy (1): high in ACCESS when the pending op is a load with wr_reg = 1, so decode stalls dependents.
- When undefined, these ports are absent and behaviour is otherwise identical.

Decomposition:
- Shared package (define.vh) holds:
  - the op encodings LB_I..SW_I;
  - DBITS, IOPBITS, REGBITS;
  - MEM latch field widths and total width;
  - the FSM state encoding.
- One sub-module, mem_lane_align: a combinational store-lane and byte-enable generator plus a load extract/extend unit, reused by a future cache.

Test Plan:
- ADD passthrough: ex_alu_out = 0x1234, rd = 5, wr_reg = 1 → next cycle wb_valid = 1, wb_result = 0x1234, wb_rd = 5; mem_stall never asserted.
- LB with ack after 3 cycles:
  - Stimulus: addr = 0x1003, rdata = 0x80FF_FFFF.
  - Request: dmem_addr = 0x1000; mem_stall high for 3 cycles.
  - Result: wb_result = 0xFFFF_FF80.
  - Repeat with LBU → 0x0000_0080.
- SH at addr = 0x2002, sd = 0xBEEF, zero-wait ack → be = 4'b1100, wdata = 0xBEEF_BEEF, wb_wr_reg = 0, no stall cycle.
- LW at addr = 0x3001 → no dmem_req, misalign_err = 1 from the next cycle and held; wb_valid = 0.
- Reset mid-access:
  - Stimulus: reset = 0 in ACCESS, then ack arrives 1 cycle after reset deasserts.
  - Required: all outputs 0, FSM in IDLE, late ack ignored.
- Back-to-back LW then ADD:
  - The ADD is held while the LW stalls.
  - The ADD completes exactly 1 cycle after the LW's wb_valid; inst_count order is preserved.
